pushbtn_poller: RTL and testbench
=================================

// Module: pushbtn_poller
// PURPOSE
//  Scan controller for a bank of Count PushBtn peripherals sharing one 12-bit instruction bus.
//  Every ScanPeriod cycles it issues a Read-Button-Status (RBS) to each device in turn and samples the reply.
//  Presses are logged in a pending mask and in a small event FIFO for the host.
//  Sits between the host/CPU glue and the PushBtn instances; the host never drives the PushBtn buses directly.
// PARAMETERS
//  Count      4      number of PushBtn devices polled (1..256)
//  IdxWidth   2      width of a device index; 2**IdxWidth >= Count
//  ScanPeriod 16     cycles between scan-round starts; must be >= 2*Count+1
//  FifoAddrW  2      event FIFO depth = 2**FifoAddrW
//  OpNop      4'h0   PushBtn NOP opcode
//  OpRbs      4'h1   PushBtn RBS opcode
// PORTS
//  clock        in   1         system clock, all state on rising edge
//  reset        in   1         asynchronous, active-low reset
//  enable       in   1         1 = periodic scanning on
//  btn_inst     out  12        shared bus to all devices: {opcode[3:0], imm[7:0]}
//  btn_inst_en  out  Count     per-device instruction enable, at most one bit high
//  btn_status   in   Count     button_status outputs of the devices
//  evt_valid    out  1         event FIFO non-empty
//  evt_index    out  IdxWidth  device index at FIFO head (valid when evt_valid=1)
//  evt_pop      in   1         pop FIFO head; ignored when evt_valid=0
//  pending      out  Count     bit i set = press of device i not yet popped
//  overflow     out  1         sticky: a press was dropped because the FIFO was full
//  overflow_clr in   1         clears overflow
// BEHAVIOUR
//  Reset (reset=0, async): btn_inst={OpNop,8'h00}, btn_inst_en=0, evt_valid=0, FIFO empty, pending=0,
//   overflow=0, FSM=WAIT, timer=0, idx=0. All outputs are registered.
//  Timer: counts 0..ScanPeriod-1 while enable=1, wraps to 0. Held at 0 while enable=0 and FSM=WAIT.
//  FSM states:
//   WAIT: bus idle ({OpNop,8'h00}, en=0). Go to ISSUE with idx=0 when timer==ScanPeriod-1 and enable=1.
//   ISSUE: exactly 1 cycle; btn_inst={OpRbs,8'h00}, btn_inst_en=1<<idx. Next state is CAPTURE.
//   CAPTURE: 1 cycle; bus idle; btn_status[idx] sampled at the closing edge.
//    Next state is WAIT if idx==Count-1, else ISSUE with idx+1.
//  One round lasts 2*Count cycles. A timer expiry during a round is impossible by the parameter rule; it is not queued.
//  enable falling mid-round: the current round completes through idx=Count-1; no further rounds start.
//  Capture with btn_status[idx]=1: pending[idx]<=1; push idx into the FIFO.
//   If the FIFO is full and there is no pop in that cycle, the push is dropped and overflow<=1 (pending is still set).
//  Capture with btn_status[idx]=0: no action.
//  Pop (evt_pop & evt_valid): head advances; pending[head] cleared.
//   If a capture sets the same bit in the same cycle, the set wins.
//  Push with pop on a full FIFO: both happen, no overflow, order preserved.
//  overflow_clr and an overflow event in the same cycle: the set wins.
//  Latency: evt_valid/evt_index update 1 cycle after the capture edge. Pop takes effect at the next edge.
//  FIFO pointers have FifoAddrW+1 bits; full/empty come from the pointer MSB compare; wrap-around is natural.
//  Reset mid-round: btn_inst_en drops to 0 immediately; after release the first ISSUE comes ScanPeriod cycles later.
// TESTING (Count=4, ScanPeriod=16, FifoAddrW=2)
//  1 reset=0 mid-activity -> btn_inst=12'h000, btn_inst_en=4'b0000, evt_valid=0, pending=4'b0000, overflow=0.
//  2 enable=1, btn_status=0 -> every 16 cycles btn_inst_en goes 0001,0000,0010,0000,0100,0000,1000,0000
//    while btn_inst=12'h100 in ISSUE cycles; no events, pending stays 0.
//  3 btn_status[2]=1 during idx=2 CAPTURE -> next cycle evt_valid=1, evt_index=2, pending=4'b0100;
//    evt_pop=1 for 1 cycle -> evt_valid=0, pending=0.
//  4 btn_status=4'b1111 for 2 rounds, no pops -> FIFO holds 0,1,2,3, overflow=1 after the 5th capture;
//    pops return 0,1,2,3 in order; overflow_clr=1 -> overflow=0.
//  5 FIFO full, evt_pop=1 in the same cycle as a capture of idx=1 -> overflow stays 0, idx=1 appears last in pop order.
//  6 enable=0 during the idx=1 ISSUE -> idx=2,3 are still polled, then btn_inst_en stays 0;
//    reset mid-round -> btn_inst_en=0 at once, FIFO empty.

Source files
------------

// File: rtl/pushbtn_poller.sv
// Purpose : scan controller polling a bank of PushBtn devices over one shared
//           12-bit instruction bus; logs presses in a pending mask and an event FIFO.
// Latency : press visible on evt_valid/evt_index/pending one cycle after the capture edge.
// Backpressure: none toward the devices; a press arriving at a full FIFO with no pop
//           is dropped and flagged on the sticky overflow bit (pending is still set).
//
// Ports:
//   clock, reset        system clock (rising edge), async active-low reset
//   enable              1 = periodic scan rounds start every ScanPeriod cycles
//   btn_inst/btn_inst_en shared {opcode, imm} bus and one-hot per-device enable
//   btn_status          button_status from each device, sampled in CAPTURE
//   evt_valid/evt_index/evt_pop  event FIFO head and pop strobe
//   pending             per-device press-not-yet-popped mask
//   overflow/overflow_clr sticky drop flag and its clear

// Small event FIFO with registered head outputs.
// Latency: a push into an empty FIFO shows on head_vld/head_dat one cycle later.
// Backpressure: push ignored while full unless a pop happens in the same cycle.
module pushbtn_evt_fifo #(
  parameter int W  = 2,
  parameter int AW = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         full,
  output logic         head_vld,
  output logic [W-1:0] head_dat
);

  localparam int Depth = 1 << AW;

  logic [AW:0]   wr_ptr, rd_ptr;
  logic [AW:0]   wr_nxt, rd_nxt;
  logic [W-1:0]  mem [Depth];
  logic          empty;
  logic          do_push, do_pop;
  logic [W-1:0]  head_nxt;

  // Extra pointer MSB distinguishes full from empty when the addresses match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_nxt = wr_ptr + (AW+1)'(do_push);
    rd_nxt = rd_ptr + (AW+1)'(do_pop);
    // The new head is the incoming word only when it lands in the slot the
    // read pointer will point at (push into an empty FIFO).
    if (do_push && (wr_ptr[AW-1:0] == rd_nxt[AW-1:0])) begin
      head_nxt = din;
    end else begin
      head_nxt = mem[rd_nxt[AW-1:0]];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      head_vld <= 1'b0;
      head_dat <= '0;
    end else begin
      wr_ptr   <= wr_nxt;
      rd_ptr   <= rd_nxt;
      head_vld <= (wr_nxt != rd_nxt);
      head_dat <= head_nxt;
    end
  end

  // Storage needs no reset: the head registers mask stale contents.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

endmodule

module pushbtn_poller #(
  parameter int         Count      = 4,
  parameter int         IdxWidth   = 2,
  parameter int         ScanPeriod = 16,
  parameter int         FifoAddrW  = 2,
  parameter logic [3:0] OpNop      = 4'h0,
  parameter logic [3:0] OpRbs      = 4'h1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  output logic [11:0]         btn_inst,
  output logic [Count-1:0]    btn_inst_en,
  input  logic [Count-1:0]    btn_status,
  output logic                evt_valid,
  output logic [IdxWidth-1:0] evt_index,
  input  logic                evt_pop,
  output logic [Count-1:0]    pending,
  output logic                overflow,
  input  logic                overflow_clr
);

  localparam int TW = (ScanPeriod > 1) ? $clog2(ScanPeriod) : 1;
  localparam logic [TW-1:0]       LastTick = TW'(ScanPeriod - 1);
  localparam logic [IdxWidth-1:0] LastIdx  = IdxWidth'(Count - 1);

  typedef enum logic [1:0] {
    S_WAIT    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [IdxWidth-1:0] idx, idx_nxt;
  logic [TW-1:0]       timer;

  logic [11:0]         inst_nxt;
  logic [Count-1:0]    en_nxt;

  logic                sel_status;
  logic                capture;
  logic                pop_eff;
  logic                fifo_full;
  logic [Count-1:0]    pending_nxt;

  // ---------------------------------------------------------------- timer
  // Free-runs while enabled. With enable low it only returns to 0 once the
  // FSM is idle, so a round in flight is not disturbed.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      timer <= '0;
    end else if (enable) begin
      timer <= (timer == LastTick) ? '0 : timer + 1'b1;
    end else if (state == S_WAIT) begin
      timer <= '0;
    end
  end

  // ------------------------------------------------------ FSM: state reg
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_WAIT;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // ----------------------------------------------------- FSM: next state
  // enable is only consulted in WAIT, so dropping it mid-round lets the
  // round run to the last device before going quiet.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    unique case (state)
      S_WAIT: begin
        if (enable && (timer == LastTick)) begin
          state_nxt = S_ISSUE;
          idx_nxt   = '0;
        end
      end
      S_ISSUE: begin
        state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (idx == LastIdx) begin
          state_nxt = S_WAIT;
        end else begin
          state_nxt = S_ISSUE;
          idx_nxt   = idx + 1'b1;
        end
      end
      default: begin
        state_nxt = S_WAIT;
        idx_nxt   = '0;
      end
    endcase
  end

  // --------------------------------------------------------- FSM: outputs
  // Bus values are computed from the next state and registered, so the bus
  // is aligned with the state the FSM is in during that cycle.
  always_comb begin
    inst_nxt = {OpNop, 8'h00};
    en_nxt   = '0;
    if (state_nxt == S_ISSUE) begin
      inst_nxt = {OpRbs, 8'h00};
      for (int i = 0; i < Count; i++) begin
        en_nxt[i] = (idx_nxt == IdxWidth'(i));
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      btn_inst    <= {OpNop, 8'h00};
      btn_inst_en <= '0;
    end else begin
      btn_inst    <= inst_nxt;
      btn_inst_en <= en_nxt;
    end
  end

  // ------------------------------------------------------- capture path
  always_comb begin
    sel_status = 1'b0;
    for (int i = 0; i < Count; i++) begin
      if (idx == IdxWidth'(i)) begin
        sel_status = btn_status[i];
      end
    end
  end

  assign capture = (state == S_CAPTURE) && sel_status;
  assign pop_eff = evt_pop && evt_valid;

  pushbtn_evt_fifo #(
    .W  (IdxWidth),
    .AW (FifoAddrW)
  ) u_evt_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (capture),
    .din      (idx),
    .pop      (pop_eff),
    .full     (fifo_full),
    .head_vld (evt_valid),
    .head_dat (evt_index)
  );

  // Clear-on-pop first, then set-on-capture, so a same-cycle set wins.
  always_comb begin
    pending_nxt = pending;
    if (pop_eff) begin
      for (int i = 0; i < Count; i++) begin
        if (evt_index == IdxWidth'(i)) begin
          pending_nxt[i] = 1'b0;
        end
      end
    end
    if (capture) begin
      for (int i = 0; i < Count; i++) begin
        if (idx == IdxWidth'(i)) begin
          pending_nxt[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      pending <= pending_nxt;
      // A pop in the same cycle frees a slot, so that push is not a drop.
      if (capture && fifo_full && !pop_eff) begin
        overflow <= 1'b1;
      end else if (overflow_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pushbtn_poller.sv
// Directed bench for pushbtn_poller (Count=4, ScanPeriod=16, FifoAddrW=2).
// Timeline after reset release with enable=1: ISSUE of idx i in round r is
// visible after cycle 16r+16+2i, its CAPTURE after 16r+17+2i, and the capture
// result after cycle 16r+18+2i.
module tb_pushbtn_poller;

  logic        clock;
  logic        reset;
  logic        enable;
  logic [11:0] btn_inst;
  logic [3:0]  btn_inst_en;
  logic [3:0]  btn_status;
  logic        evt_valid;
  logic [1:0]  evt_index;
  logic        evt_pop;
  logic [3:0]  pending;
  logic        overflow;
  logic        overflow_clr;

  int tests;
  int fails;
  int cyc;

  pushbtn_poller #(
    .Count      (4),
    .IdxWidth   (2),
    .ScanPeriod (16),
    .FifoAddrW  (2),
    .OpNop      (4'h0),
    .OpRbs      (4'h1)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .btn_inst     (btn_inst),
    .btn_inst_en  (btn_inst_en),
    .btn_status   (btn_status),
    .evt_valid    (evt_valid),
    .evt_index    (evt_index),
    .evt_pop      (evt_pop),
    .pending      (pending),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  // Hold reset over two edges, release between edges; cycle 1 is the first
  // edge after release.
  task automatic do_reset(input logic en, input logic [3:0] st);
    reset        = 1'b0;
    enable       = en;
    btn_status   = st;
    evt_pop      = 1'b0;
    overflow_clr = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    cyc   = 0;
  endtask

  task automatic test_reset();
    // Power-up state
    tests++;
    if ({btn_inst, btn_inst_en, evt_valid, pending, overflow} !== {12'h000, 4'b0000, 1'b0, 4'b0000, 1'b0}) begin
      fails++;
      $display("FAIL reset_init: inst=%h en=%b vld=%b pend=%b ovf=%b required 000/0000/0/0000/0",
               btn_inst, btn_inst_en, evt_valid, pending, overflow);
    end
    // Reset mid-round with events logged
    do_reset(1'b1, 4'b1111);
    run_to(22);
    tests++;
    if (btn_inst_en !== 4'b1000 || pending !== 4'b0111 || evt_valid !== 1'b1) begin
      fails++;
      $display("FAIL reset_pre_activity: en=%b pend=%b vld=%b required 1000/0111/1",
               btn_inst_en, pending, evt_valid);
    end
    reset = 1'b0;
    #1;
    tests++;
    if ({btn_inst, btn_inst_en, evt_valid, pending, overflow} !== {12'h000, 4'b0000, 1'b0, 4'b0000, 1'b0}) begin
      fails++;
      $display("FAIL reset_async: inst=%h en=%b vld=%b pend=%b ovf=%b required 000/0000/0/0000/0",
               btn_inst, btn_inst_en, evt_valid, pending, overflow);
    end
    btn_status = 4'b0000;
    tick();
    reset = 1'b1;
    cyc   = 0;
    run_to(15);
    tests++;
    if (btn_inst_en !== 4'b0000 || evt_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_release_early: en=%b vld=%b required 0000/0", btn_inst_en, evt_valid);
    end
    run_to(16);
    tests++;
    if (btn_inst_en !== 4'b0001 || btn_inst !== 12'h100) begin
      fails++;
      $display("FAIL reset_release_issue: en=%b inst=%h required 0001/100", btn_inst_en, btn_inst);
    end
  endtask

  task automatic test_scan();
    int          ph;
    logic [3:0]  exp_en;
    logic [11:0] exp_inst;
    do_reset(1'b1, 4'b0000);
    for (int c = 1; c <= 50; c++) begin
      tick();
      exp_en = 4'b0000;
      if (cyc >= 16) begin
        ph = (cyc - 16) % 16;
        if (ph < 8 && (ph % 2) == 0) exp_en = 4'b0001 << (ph / 2);
      end
      exp_inst = (exp_en != 4'b0000) ? 12'h100 : 12'h000;
      tests++;
      if (btn_inst_en !== exp_en || btn_inst !== exp_inst || evt_valid !== 1'b0 || pending !== 4'b0000) begin
        fails++;
        $display("FAIL scan_cyc%0d: en=%b inst=%h vld=%b pend=%b required %b/%h/0/0000",
                 cyc, btn_inst_en, btn_inst, evt_valid, pending, exp_en, exp_inst);
      end
    end
  endtask

  task automatic test_single_press();
    do_reset(1'b1, 4'b0000);
    run_to(21);
    btn_status = 4'b0100;
    tests++;
    if (evt_valid !== 1'b0) begin
      fails++;
      $display("FAIL press_early: vld=%b required 0", evt_valid);
    end
    tick();
    btn_status = 4'b0000;
    tests++;
    if (evt_valid !== 1'b1 || evt_index !== 2'd2 || pending !== 4'b0100) begin
      fails++;
      $display("FAIL press_logged: vld=%b idx=%0d pend=%b required 1/2/0100", evt_valid, evt_index, pending);
    end
    // Pop of idx 2 coinciding with a new capture of idx 2: the set wins.
    run_to(37);
    evt_pop    = 1'b1;
    btn_status = 4'b0100;
    tick();
    evt_pop    = 1'b0;
    btn_status = 4'b0000;
    tests++;
    if (evt_valid !== 1'b1 || evt_index !== 2'd2 || pending !== 4'b0100) begin
      fails++;
      $display("FAIL press_set_wins: vld=%b idx=%0d pend=%b required 1/2/0100", evt_valid, evt_index, pending);
    end
    evt_pop = 1'b1;
    tick();
    evt_pop = 1'b0;
    tests++;
    if (evt_valid !== 1'b0 || pending !== 4'b0000) begin
      fails++;
      $display("FAIL press_popped: vld=%b pend=%b required 0/0000", evt_valid, pending);
    end
  endtask

  task automatic test_overflow();
    do_reset(1'b1, 4'b1111);
    run_to(24);
    tests++;
    if (evt_valid !== 1'b1 || evt_index !== 2'd0 || pending !== 4'b1111 || overflow !== 1'b0) begin
      fails++;
      $display("FAIL ovf_full: vld=%b idx=%0d pend=%b ovf=%b required 1/0/1111/0",
               evt_valid, evt_index, pending, overflow);
    end
    run_to(34);
    tests++;
    if (overflow !== 1'b1) begin
      fails++;
      $display("FAIL ovf_set: ovf=%b required 1", overflow);
    end
    run_to(40);
    btn_status = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (evt_valid !== 1'b1 || evt_index !== 2'(k)) begin
        fails++;
        $display("FAIL ovf_pop%0d: vld=%b idx=%0d required 1/%0d", k, evt_valid, evt_index, k);
      end
      evt_pop = 1'b1;
      tick();
      evt_pop = 1'b0;
    end
    tests++;
    if (evt_valid !== 1'b0 || pending !== 4'b0000 || overflow !== 1'b1) begin
      fails++;
      $display("FAIL ovf_drained: vld=%b pend=%b ovf=%b required 0/0000/1", evt_valid, pending, overflow);
    end
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    tests++;
    if (overflow !== 1'b0) begin
      fails++;
      $display("FAIL ovf_clear: ovf=%b required 0", overflow);
    end
  endtask

  task automatic test_push_pop_full();
    logic [1:0] exp_order [4];
    exp_order[0] = 2'd1;
    exp_order[1] = 2'd2;
    exp_order[2] = 2'd3;
    exp_order[3] = 2'd1;
    do_reset(1'b1, 4'b1111);
    run_to(24);
    btn_status = 4'b0010;
    run_to(35);
    evt_pop = 1'b1;
    tick();
    evt_pop    = 1'b0;
    btn_status = 4'b0000;
    tests++;
    if (overflow !== 1'b0 || evt_valid !== 1'b1 || evt_index !== 2'd1 || pending !== 4'b1110) begin
      fails++;
      $display("FAIL pushpop_same: ovf=%b vld=%b idx=%0d pend=%b required 0/1/1/1110",
               overflow, evt_valid, evt_index, pending);
    end
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (evt_valid !== 1'b1 || evt_index !== exp_order[k]) begin
        fails++;
        $display("FAIL pushpop_order%0d: vld=%b idx=%0d required 1/%0d", k, evt_valid, evt_index, exp_order[k]);
      end
      evt_pop = 1'b1;
      tick();
      evt_pop = 1'b0;
    end
    tests++;
    if (evt_valid !== 1'b0 || overflow !== 1'b0) begin
      fails++;
      $display("FAIL pushpop_end: vld=%b ovf=%b required 0/0", evt_valid, overflow);
    end
  endtask

  task automatic test_enable_drop();
    logic [3:0] exp_en;
    do_reset(1'b1, 4'b0000);
    run_to(18);
    tests++;
    if (btn_inst_en !== 4'b0010) begin
      fails++;
      $display("FAIL endrop_issue1: en=%b required 0010", btn_inst_en);
    end
    enable = 1'b0;
    for (int c = 19; c <= 60; c++) begin
      tick();
      exp_en = (cyc == 20) ? 4'b0100 : (cyc == 22) ? 4'b1000 : 4'b0000;
      tests++;
      if (btn_inst_en !== exp_en) begin
        fails++;
        $display("FAIL endrop_cyc%0d: en=%b required %b", cyc, btn_inst_en, exp_en);
      end
    end
  endtask

  initial begin
    tests        = 0;
    fails        = 0;
    cyc          = 0;
    reset        = 1'b0;
    enable       = 1'b0;
    btn_status   = 4'b0000;
    evt_pop      = 1'b0;
    overflow_clr = 1'b0;
    tick();
    tick();
    test_reset();
    test_scan();
    test_single_press();
    test_overflow();
    test_push_pop_full();
    test_enable_drop();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
